// File: rtl/regfile_mp.sv
// Multi-port integer register file with a per-register pending-write scoreboard.
// Combinational reads with optional same-cycle write bypass; synchronous writes.
module regfile_mp #(
  parameter int  DATA_W  = 32,
  parameter int  NREG    = 32,
  parameter int  NRD     = 2,
  parameter int  NWR     = 2,
  parameter bit  BYPASS  = 1'b1,
  parameter bit  ZERO_R0 = 1'b1,
  localparam int AW      = $clog2(NREG)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NRD*AW-1:0]     raddr,
  output logic [NRD*DATA_W-1:0] rdata,
  output logic [NRD-1:0]        rbusy,
  input  logic [NWR-1:0]        we,
  input  logic [NWR*AW-1:0]     waddr,
  input  logic [NWR*DATA_W-1:0] wdata,
  input  logic [NWR-1:0]        set_en,
  input  logic [NWR*AW-1:0]     set_addr,
  input  logic                  flush
);

  logic [DATA_W-1:0] rf [NREG];
  logic [NREG-1:0]   sb;
  logic [NREG-1:0]   sb_next;

  // Ascending port order makes the younger (higher-index) write the last NBA, so it wins.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rf <= '{default: '0};
      sb <= '0;
    end else begin
      for (int unsigned j = 0; j < NWR; j++) begin
        if (we[j] && !(ZERO_R0 && waddr[j*AW +: AW] == '0))
          rf[waddr[j*AW +: AW]] <= wdata[j*DATA_W +: DATA_W];
      end
      sb <= sb_next;
    end
  end

  // Clears first, then sets over them, then flush over everything: flush > set > clear > hold.
  always_comb begin
    sb_next = sb;
    for (int unsigned j = 0; j < NWR; j++) begin
      if (we[j])
        sb_next[waddr[j*AW +: AW]] = 1'b0;
    end
    for (int unsigned j = 0; j < NWR; j++) begin
      if (set_en[j])
        sb_next[set_addr[j*AW +: AW]] = 1'b1;
    end
    if (flush)
      sb_next = '0;
    if (ZERO_R0)
      sb_next[0] = 1'b0;
  end

  always_comb begin
    rdata = '0;
    rbusy = '0;
    for (int unsigned i = 0; i < NRD; i++) begin
      rdata[i*DATA_W +: DATA_W] = rf[raddr[i*AW +: AW]];
      rbusy[i]                  = sb[raddr[i*AW +: AW]];
      if (BYPASS) begin
        for (int unsigned j = 0; j < NWR; j++) begin
          if (we[j] && waddr[j*AW +: AW] == raddr[i*AW +: AW]) begin
            rdata[i*DATA_W +: DATA_W] = wdata[j*DATA_W +: DATA_W];
            rbusy[i]                  = 1'b0;
          end
        end
        if (flush)
          rbusy[i] = 1'b0;
      end
      if (ZERO_R0 && raddr[i*AW +: AW] == '0) begin
        rdata[i*DATA_W +: DATA_W] = '0;
        rbusy[i]                  = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a 4-read bypassing instance and a 2-read non-bypassing instance
// share write/issue traffic; directed vectors first, then random traffic against a model.
module tb_regfile_mp;

  logic         clk;
  logic         resetn;
  logic [19:0]  raddr;
  logic [127:0] rdata;
  logic [3:0]   rbusy;
  logic [63:0]  nb_rdata;
  logic [1:0]   nb_rbusy;
  logic [1:0]   we;
  logic [9:0]   waddr;
  logic [63:0]  wdata;
  logic [1:0]   set_en;
  logic [9:0]   set_addr;
  logic         flush;

  regfile_mp #(.DATA_W(32), .NREG(32), .NRD(4), .NWR(2), .BYPASS(1'b1), .ZERO_R0(1'b1)) dut (
    .clk(clk), .resetn(resetn), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .we(we), .waddr(waddr), .wdata(wdata), .set_en(set_en), .set_addr(set_addr), .flush(flush)
  );

  regfile_mp #(.DATA_W(32), .NREG(32), .NRD(2), .NWR(2), .BYPASS(1'b0), .ZERO_R0(1'b1)) dut_nb (
    .clk(clk), .resetn(resetn), .raddr(raddr[9:0]), .rdata(nb_rdata), .rbusy(nb_rbusy),
    .we(we), .waddr(waddr), .wdata(wdata), .set_en(set_en), .set_addr(set_addr), .flush(flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic [1:0]  we;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic [1:0]  se;
    logic [4:0]  sa0, sa1;
    logic        fl;
    logic [4:0]  ra0, ra1;
    logic        chk;
    logic [31:0] er0, er1;
    logic        eb0, eb1;
    logic [31:0] enb;
    logic        enbb;
  } vec_t;

  typedef struct packed {
    logic [127:0] rd;
    logic [3:0]   rb;
    logic [3:0]   m;
    logic [63:0]  nrd;
    logic [1:0]   nrb;
    logic [1:0]   nm;
    int           cyc;
  } exp_t;

  vec_t        tbl [19];
  exp_t        expq [$];
  logic [31:0] rf_m [32];
  logic [31:0] sb_m;
  int          checks = 0;
  int          errors = 0;
  int          cycle  = 0;

  task automatic chk(input string nm, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  function automatic void exp_read(input bit byp, input logic [4:0] a,
                                   output logic [31:0] d, output logic b);
    d = rf_m[a];
    b = sb_m[a];
    if (byp) begin
      for (int j = 0; j < 2; j++) begin
        if (we[j] && waddr[j*5 +: 5] == a) begin
          d = wdata[j*32 +: 32];
          b = 1'b0;
        end
      end
      if (flush) b = 1'b0;
    end
    if (a == 5'd0) begin
      d = '0;
      b = 1'b0;
    end
  endfunction

  function automatic logic [4:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  task automatic push_model();
    exp_t e;
    logic [31:0] d;
    logic b;
    e = '0;
    e.cyc = cycle;
    for (int p = 0; p < 4; p++) begin
      exp_read(1'b1, raddr[p*5 +: 5], d, b);
      e.rd[p*32 +: 32] = d;
      e.rb[p] = b;
    end
    for (int p = 0; p < 2; p++) begin
      exp_read(1'b0, raddr[p*5 +: 5], d, b);
      e.nrd[p*32 +: 32] = d;
      e.nrb[p] = b;
    end
    e.m  = 4'hF;
    e.nm = 2'b11;
    expq.push_back(e);
  endtask

  task automatic model_update();
    logic [31:0] sb_n;
    if (!resetn) begin
      for (int r = 0; r < 32; r++) rf_m[r] = '0;
      sb_m = '0;
    end else begin
      sb_n = sb_m;
      for (int r = 1; r < 32; r++) begin
        if (flush)
          sb_n[r] = 1'b0;
        else if ((set_en[0] && set_addr[4:0] == 5'(r)) || (set_en[1] && set_addr[9:5] == 5'(r)))
          sb_n[r] = 1'b1;
        else if ((we[0] && waddr[4:0] == 5'(r)) || (we[1] && waddr[9:5] == 5'(r)))
          sb_n[r] = 1'b0;
      end
      sb_m = sb_n;
      for (int j = 0; j < 2; j++)
        if (we[j] && waddr[j*5 +: 5] != 5'd0) rf_m[waddr[j*5 +: 5]] = wdata[j*32 +: 32];
    end
  endtask

  // Compare combinational outputs at negedge, then advance the model on posedge.
  task automatic cyc_step();
    exp_t e;
    @(negedge clk);
    if (expq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard cycle %0d: got empty queue expected an entry", cycle);
    end else begin
      e = expq.pop_front();
      for (int p = 0; p < 4; p++) begin
        if (e.m[p]) begin
          chk($sformatf("rdata%0d", p), e.cyc, rdata[p*32 +: 32], e.rd[p*32 +: 32]);
          chk($sformatf("rbusy%0d", p), e.cyc, 32'(rbusy[p]), 32'(e.rb[p]));
        end
      end
      for (int p = 0; p < 2; p++) begin
        if (e.nm[p]) begin
          chk($sformatf("nb_rdata%0d", p), e.cyc, nb_rdata[p*32 +: 32], e.nrd[p*32 +: 32]);
          chk($sformatf("nb_rbusy%0d", p), e.cyc, 32'(nb_rbusy[p]), 32'(e.nrb[p]));
        end
      end
    end
    @(posedge clk);
    model_update();
    cycle++;
    #1;
  endtask

  initial begin
    exp_t e;
    // rst we wa0 wa1 wd0 wd1 se sa0 sa1 fl ra0 ra1 chk er0 er1 eb0 eb1 enb enbb
    tbl[0]  = '{1'b0, 2'b11, 5'd5, 5'd6, 32'h1111, 32'h2222, 2'b11, 5'd3, 5'd4, 1'b0, 5'd1, 5'd2, 1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0};
    tbl[1]  = '{1'b0, 2'b11, 5'd5, 5'd6, 32'h1111, 32'h2222, 2'b11, 5'd3, 5'd4, 1'b0, 5'd1, 5'd2, 1'b1, '0, '0, 1'b0, 1'b0, '0, 1'b0};
    tbl[2]  = '{1'b1, 2'b00, '0, '0, '0, '0, 2'b00, '0, '0, 1'b0, 5'd5, 5'd3, 1'b1, '0, '0, 1'b0, 1'b0, '0, 1'b0};
    tbl[3]  = '{1'b1, 2'b01, 5'd5, '0, 32'hDEAD_BEEF, '0, 2'b00, '0, '0, 1'b0, 5'd5, 5'd5, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0, '0, 1'b0};
    tbl[4]  = '{1'b1, 2'b00, '0, '0, '0, '0, 2'b00, '0, '0, 1'b0, 5'd5, 5'd5, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0};
    tbl[5]  = '{1'b1, 2'b11, 5'd7, 5'd7, 32'd1, 32'd2, 2'b00, '0, '0, 1'b0, 5'd7, 5'd7, 1'b1, 32'd2, 32'd2, 1'b0, 1'b0, '0, 1'b0};
    tbl[6]  = '{1'b1, 2'b00, '0, '0, '0, '0, 2'b00, '0, '0, 1'b0, 5'd7, 5'd5, 1'b1, 32'd2, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'd2, 1'b0};
    tbl[7]  = '{1'b1, 2'b01, 5'd0, '0, 32'hFFFF_FFFF, '0, 2'b01, 5'd0, '0, 1'b0, 5'd0, 5'd0, 1'b1, '0, '0, 1'b0, 1'b0, '0, 1'b0};
    tbl[8]  = '{1'b1, 2'b00, '0, '0, '0, '0, 2'b00, '0, '0, 1'b0, 5'd0, 5'd0, 1'b1, '0, '0, 1'b0, 1'b0, '0, 1'b0};
    tbl[9]  = '{1'b1, 2'b00, '0, '0, '0, '0, 2'b01, 5'd3, '0, 1'b0, 5'd3, 5'd3, 1'b1, '0, '0, 1'b0, 1'b0, '0, 1'b0};
    tbl[10] = '{1'b1, 2'b00, '0, '0, '0, '0, 2'b00, '0, '0, 1'b0, 5'd3, 5'd0, 1'b1, '0, '0, 1'b1, 1'b0, '0, 1'b1};
    tbl[11] = '{1'b1, 2'b00, '0, '0, '0, '0, 2'b00, '0, '0, 1'b0, 5'd3, 5'd0, 1'b1, '0, '0, 1'b1, 1'b0, '0, 1'b1};
    tbl[12] = '{1'b1, 2'b01, 5'd3, '0, 32'h33, '0, 2'b01, 5'd3, '0, 1'b0, 5'd3, 5'd3, 1'b1, 32'h33, 32'h33, 1'b0, 1'b0, '0, 1'b1};
    tbl[13] = '{1'b1, 2'b00, '0, '0, '0, '0, 2'b00, '0, '0, 1'b0, 5'd3, 5'd3, 1'b1, 32'h33, 32'h33, 1'b1, 1'b1, 32'h33, 1'b1};
    tbl[14] = '{1'b1, 2'b00, '0, '0, '0, '0, 2'b00, '0, '0, 1'b1, 5'd3, 5'd3, 1'b1, 32'h33, 32'h33, 1'b0, 1'b0, 32'h33, 1'b1};
    tbl[15] = '{1'b1, 2'b00, '0, '0, '0, '0, 2'b00, '0, '0, 1'b0, 5'd3, 5'd3, 1'b1, 32'h33, 32'h33, 1'b0, 1'b0, 32'h33, 1'b0};
    tbl[16] = '{1'b1, 2'b00, '0, '0, '0, '0, 2'b10, '0, 5'd9, 1'b0, 5'd9, 5'd9, 1'b1, '0, '0, 1'b0, 1'b0, '0, 1'b0};
    tbl[17] = '{1'b1, 2'b01, 5'd9, '0, 32'h99, '0, 2'b00, '0, '0, 1'b0, 5'd9, 5'd9, 1'b1, 32'h99, 32'h99, 1'b0, 1'b0, '0, 1'b1};
    tbl[18] = '{1'b1, 2'b00, '0, '0, '0, '0, 2'b00, '0, '0, 1'b0, 5'd9, 5'd9, 1'b1, 32'h99, 32'h99, 1'b0, 1'b0, 32'h99, 1'b0};

    for (int r = 0; r < 32; r++) rf_m[r] = '0;
    sb_m = '0;
    resetn = 1'b0; raddr = '0; we = '0; waddr = '0; wdata = '0;
    set_en = '0; set_addr = '0; flush = 1'b0;
    @(posedge clk);
    #1;

    for (int k = 0; k < 19; k++) begin
      resetn   = tbl[k].rst;
      we       = tbl[k].we;
      waddr    = {tbl[k].wa1, tbl[k].wa0};
      wdata    = {tbl[k].wd1, tbl[k].wd0};
      set_en   = tbl[k].se;
      set_addr = {tbl[k].sa1, tbl[k].sa0};
      flush    = tbl[k].fl;
      raddr    = {10'd0, tbl[k].ra1, tbl[k].ra0};
      e        = '0;
      e.cyc    = cycle;
      e.rd     = {64'd0, tbl[k].er1, tbl[k].er0};
      e.rb     = {2'b00, tbl[k].eb1, tbl[k].eb0};
      e.m      = tbl[k].chk ? 4'b0011 : 4'b0000;
      e.nrd    = {32'd0, tbl[k].enb};
      e.nrb    = {1'b0, tbl[k].enbb};
      e.nm     = tbl[k].chk ? 2'b01 : 2'b00;
      expq.push_back(e);
      cyc_step();
    end

    for (int n = 0; n < 10000; n++) begin
      resetn = ($urandom_range(0, 99) != 0);
      we     = 2'($urandom);
      waddr  = {rnd_addr(), rnd_addr()};
      wdata  = {$urandom, $urandom};
      set_en = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
      set_addr = {rnd_addr(), rnd_addr()};
      flush  = ($urandom_range(0, 31) == 0);
      raddr  = {rnd_addr(), rnd_addr(), rnd_addr(), rnd_addr()};
      push_model();
      cyc_step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
